// File: rtl/eq_sched_pkg.sv
// Shared definitions for the two-model equivalence step scheduler.
//   phase_e   : scheduler phase encoding, also driven out on the phase port
//   DefDataW  : default stream data width
//   DefCntW   : default width of the cycle and match counters
//   start_ok(): phases in which a start pulse launches a new run
package eq_sched_pkg;

  localparam int unsigned DefDataW = 8;
  localparam int unsigned DefCntW  = 16;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StRun   = 3'd1,
    StDrain = 3'd2,
    StCheck = 3'd3,
    StDone  = 3'd4
  } phase_e;

  function automatic logic start_ok(input phase_e p);
    return (p == StIdle) || (p == StDone);
  endfunction

endpackage

// File: rtl/eq_sync_fifo.sv
// Synchronous FIFO that buffers one model's output stream.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous flush (takes priority over push/pop)
//   push/wdata : write one entry (ignored when full)
//   pop/rdata  : read one entry (ignored when empty); rdata shows the head
//   full/empty : occupancy flags
// DEPTH must be a power of two so the pointers wrap naturally.
module eq_sync_fifo #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              push,
  input  logic [DATA_W-1:0] wdata,
  input  logic              pop,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FullCnt = (AW + 1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wptr_q, rptr_q;
  logic [AW:0]       cnt_q, cnt_d;
  logic              push_en, pop_en;

  assign full    = (cnt_q == FullCnt);
  assign empty   = (cnt_q == '0);
  assign push_en = push & ~full;
  assign pop_en  = pop & ~empty;
  assign rdata   = mem_q[rptr_q];

  always_comb begin
    cnt_d = cnt_q;
    unique case ({push_en, pop_en})
      2'b10:   cnt_d = cnt_q + (AW + 1)'(1);
      2'b01:   cnt_d = cnt_q - (AW + 1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else if (clr) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push_en) wptr_q <= wptr_q + AW'(1);
      if (pop_en)  rptr_q <= rptr_q + AW'(1);
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset: only entries behind a valid count are ever read.
  always_ff @(posedge clk) begin
    if (push_en && !clr) mem_q[wptr_q] <= wdata;
  end

endmodule

// File: rtl/eq_step_sched.sv
// Equivalence-run sequencer for a high-level model A and a detailed model B.
// Broadcasts each input beat to both models in lockstep, gives each model a step enable
// instead of a gated clock, buffers both output streams and compares them beat by beat.
//   clk, rst_n                 : clock, asynchronous active-low reset
//   start                      : begin a run (honoured in IDLE and DONE only)
//   in_tdata/in_tvalid/in_tready : shared input stream
//   a_step, b_step             : per-model step enables
//   x_in_tvalid / x_in_tready  : input handshake towards model x (data is in_tdata)
//   x_out_tdata/tvalid/tready  : output stream from model x
//   a_complete, b_complete     : model reports run finished
//   phase, cyc_cnt, match_cnt  : status: FSM phase, RUN cycles, equal beats
//   mismatch, done             : sticky divergence flag, run finished
// Optional: define EQ_TRACE_EN to add mm_idx/mm_a/mm_b, capturing the first data mismatch.
module eq_step_sched
  import eq_sched_pkg::*;
#(
  parameter int unsigned DATA_W    = DefDataW,
  parameter int unsigned OUT_DEPTH = 4,
  parameter int unsigned MAX_CYC   = 16,
  parameter int unsigned CNT_W     = DefCntW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] in_tdata,
  input  logic              in_tvalid,
  output logic              in_tready,
  output logic              a_step,
  output logic              b_step,
  output logic              a_in_tvalid,
  output logic              b_in_tvalid,
  input  logic              a_in_tready,
  input  logic              b_in_tready,
  input  logic [DATA_W-1:0] a_out_tdata,
  input  logic [DATA_W-1:0] b_out_tdata,
  input  logic              a_out_tvalid,
  input  logic              b_out_tvalid,
  output logic              a_out_tready,
  output logic              b_out_tready,
  input  logic              a_complete,
  input  logic              b_complete,
  output logic [2:0]        phase,
  output logic [CNT_W-1:0]  cyc_cnt,
  output logic [CNT_W-1:0]  match_cnt,
  output logic              mismatch,
  output logic              done
`ifdef EQ_TRACE_EN
  ,
  output logic [CNT_W-1:0]  mm_idx,
  output logic [DATA_W-1:0] mm_a,
  output logic [DATA_W-1:0] mm_b
`endif
);

  localparam logic [CNT_W-1:0] CycMax = CNT_W'(MAX_CYC - 1);

  phase_e            phase_q;
  logic [CNT_W-1:0]  cyc_q, match_q;
  logic              mismatch_q;

  logic              in_run, in_cap, run_start;
  logic              a_full, a_empty, b_full, b_empty;
  logic [DATA_W-1:0] a_head, b_head;
  logic              a_push, b_push, cmp, cmp_eq, fire;

  assign in_run    = (phase_q == StRun);
  assign in_cap    = in_run | (phase_q == StDrain);
  assign run_start = start & start_ok(phase_q);

  // Steps are decoded straight from the phase register so an async reset drops them at once.
  assign a_step = in_run & ~a_complete & ~a_full;
  assign b_step = in_run & ~b_complete & ~b_full;

  // Ready only when both models can take the beat together; a beat never reaches just one.
  assign in_tready   = in_run & a_step & b_step & a_in_tready & b_in_tready;
  assign fire        = in_tvalid & in_tready;
  assign a_in_tvalid = fire;
  assign b_in_tvalid = fire;

  assign a_out_tready = in_cap & ~a_full;
  assign b_out_tready = in_cap & ~b_full;
  assign a_push       = a_out_tvalid & a_out_tready;
  assign b_push       = b_out_tvalid & b_out_tready;

  assign cmp    = in_cap & ~a_empty & ~b_empty;
  assign cmp_eq = (a_head == b_head);

  eq_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (OUT_DEPTH)
  ) u_buf_a (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (run_start),
    .push  (a_push),
    .wdata (a_out_tdata),
    .pop   (cmp),
    .rdata (a_head),
    .full  (a_full),
    .empty (a_empty)
  );

  eq_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (OUT_DEPTH)
  ) u_buf_b (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (run_start),
    .push  (b_push),
    .wdata (b_out_tdata),
    .pop   (cmp),
    .rdata (b_head),
    .full  (b_full),
    .empty (b_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q    <= StIdle;
      cyc_q      <= '0;
      match_q    <= '0;
      mismatch_q <= 1'b0;
    end else begin
      unique case (phase_q)
        StIdle, StDone: begin
          if (start) begin
            phase_q    <= StRun;
            cyc_q      <= '0;
            match_q    <= '0;
            mismatch_q <= 1'b0;
          end
        end
        StRun: begin
          if (cyc_q != CycMax) cyc_q <= cyc_q + CNT_W'(1);
          if ((a_complete && b_complete) || (cyc_q == CycMax)) phase_q <= StDrain;
        end
        StDrain: begin
          if (a_empty || b_empty) phase_q <= StCheck;
        end
        StCheck: begin
          // Leftover beats in either buffer mean the streams differed in length.
          if (!a_empty || !b_empty) mismatch_q <= 1'b1;
          phase_q <= StDone;
        end
        default: phase_q <= StIdle;
      endcase

      // cmp is only possible in RUN/DRAIN, so it never collides with the start clear.
      if (cmp) begin
        if (!cmp_eq)               mismatch_q <= 1'b1;
        else if (match_q != '1)    match_q    <= match_q + CNT_W'(1);
      end
    end
  end

`ifdef EQ_TRACE_EN
  logic [CNT_W-1:0]  mm_idx_q;
  logic [DATA_W-1:0] mm_a_q, mm_b_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mm_idx_q <= '0;
      mm_a_q   <= '0;
      mm_b_q   <= '0;
    end else if (run_start) begin
      mm_idx_q <= '0;
      mm_a_q   <= '0;
      mm_b_q   <= '0;
    end else if (cmp && !cmp_eq && !mismatch_q) begin
      mm_idx_q <= match_q;
      mm_a_q   <= a_head;
      mm_b_q   <= b_head;
    end
  end

  assign mm_idx = mm_idx_q;
  assign mm_a   = mm_a_q;
  assign mm_b   = mm_b_q;
`endif

  assign phase     = phase_q;
  assign cyc_cnt   = cyc_q;
  assign match_cnt = match_q;
  assign mismatch  = mismatch_q;
  assign done      = (phase_q == StDone);

endmodule

// File: tb/tb_eq_step_sched.sv
// Directed bench for eq_step_sched: the bench plays both models and checks status outputs
// against hand-computed values at fixed points in each run.
module tb_eq_step_sched;

  localparam int unsigned DW = 8;
  localparam int unsigned CW = 16;

  logic          clk, rst_n, start;
  logic [DW-1:0] in_tdata;
  logic          in_tvalid, in_tready;
  logic          a_step, b_step, a_in_tvalid, b_in_tvalid, a_in_tready, b_in_tready;
  logic [DW-1:0] a_out_tdata, b_out_tdata;
  logic          a_out_tvalid, b_out_tvalid, a_out_tready, b_out_tready;
  logic          a_complete, b_complete;
  logic [2:0]    phase;
  logic [CW-1:0] cyc_cnt, match_cnt;
  logic          mismatch, done;
`ifdef EQ_TRACE_EN
  logic [CW-1:0] mm_idx;
  logic [DW-1:0] mm_a, mm_b;
`endif

  int total = 0;
  int bad   = 0;

  eq_step_sched #(
    .DATA_W    (DW),
    .OUT_DEPTH (4),
    .MAX_CYC   (16),
    .CNT_W     (CW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .in_tdata     (in_tdata),
    .in_tvalid    (in_tvalid),
    .in_tready    (in_tready),
    .a_step       (a_step),
    .b_step       (b_step),
    .a_in_tvalid  (a_in_tvalid),
    .b_in_tvalid  (b_in_tvalid),
    .a_in_tready  (a_in_tready),
    .b_in_tready  (b_in_tready),
    .a_out_tdata  (a_out_tdata),
    .b_out_tdata  (b_out_tdata),
    .a_out_tvalid (a_out_tvalid),
    .b_out_tvalid (b_out_tvalid),
    .a_out_tready (a_out_tready),
    .b_out_tready (b_out_tready),
    .a_complete   (a_complete),
    .b_complete   (b_complete),
    .phase        (phase),
    .cyc_cnt      (cyc_cnt),
    .match_cnt    (match_cnt),
    .mismatch     (mismatch),
    .done         (done)
`ifdef EQ_TRACE_EN
    ,
    .mm_idx       (mm_idx),
    .mm_a         (mm_a),
    .mm_b         (mm_b)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] d1 [3];
    d1 = '{8'h11, 8'h22, 8'h33};

    rst_n = 1'b0; start = 1'b0;
    in_tdata = '0; in_tvalid = 1'b1;
    a_in_tready = 1'b1; b_in_tready = 1'b1;
    a_out_tdata = '0; b_out_tdata = '0; a_out_tvalid = 1'b0; b_out_tvalid = 1'b0;
    a_complete = 1'b0; b_complete = 1'b0;

    // 1. reset state, then a clean three-beat echo run
    #3;
    chk("rst_phase", 32'(phase), 32'd0);
    chk("rst_cyc", 32'(cyc_cnt), 32'd0);
    chk("rst_match", 32'(match_cnt), 32'd0);
    chk("rst_mismatch", 32'(mismatch), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_steps", 32'({a_step, b_step}), 32'd0);
    chk("rst_in_tready", 32'(in_tready), 32'd0);
    chk("rst_out_tready", 32'({a_out_tready, b_out_tready}), 32'd0);
    in_tvalid = 1'b0;
    step(); step();
    rst_n = 1'b1;
    do_start();
    chk("t1_phase_run", 32'(phase), 32'd1);
    chk("t1_cyc0", 32'(cyc_cnt), 32'd0);
    chk("t1_a_step", 32'(a_step), 32'd1);
    for (int i = 0; i < 3; i++) begin
      in_tvalid = 1'b1; in_tdata = d1[i];
      a_out_tvalid = 1'b1; b_out_tvalid = 1'b1;
      a_out_tdata = d1[i]; b_out_tdata = d1[i];
      #1;
      if (i == 0) begin
        chk("t1_in_tready", 32'(in_tready), 32'd1);
        chk("t1_model_valid", 32'({a_in_tvalid, b_in_tvalid}), 32'd3);
      end
      step();
    end
    in_tvalid = 1'b0; a_out_tvalid = 1'b0; b_out_tvalid = 1'b0;
    a_complete = 1'b1; b_complete = 1'b1;
    #1;
    chk("t1_step_off_complete", 32'({a_step, b_step}), 32'd0);
    step();
    chk("t1_phase_drain", 32'(phase), 32'd2);
    chk("t1_cyc4", 32'(cyc_cnt), 32'd4);
    step();
    chk("t1_phase_check", 32'(phase), 32'd3);
    step();
    chk("t1_phase_done", 32'(phase), 32'd4);
    chk("t1_done", 32'(done), 32'd1);
    chk("t1_match3", 32'(match_cnt), 32'd3);
    chk("t1_mismatch0", 32'(mismatch), 32'd0);
    chk("t1_cyc_hold", 32'(cyc_cnt), 32'd4);

    // 2. data divergence at beat 2 (A=0x23, B=0x22)
    a_complete = 1'b0; b_complete = 1'b0;
    do_start();
    chk("t2_restart_match", 32'(match_cnt), 32'd0);
    chk("t2_restart_cyc", 32'(cyc_cnt), 32'd0);
    a_out_tvalid = 1'b1; b_out_tvalid = 1'b1;
    a_out_tdata = 8'h11; b_out_tdata = 8'h11;
    step();
    a_out_tdata = 8'h23; b_out_tdata = 8'h22;
    step();
    a_out_tvalid = 1'b0; b_out_tvalid = 1'b0;
    chk("t2_pre_mismatch", 32'(mismatch), 32'd0);
    step();
    chk("t2_mismatch", 32'(mismatch), 32'd1);
    chk("t2_match1", 32'(match_cnt), 32'd1);
`ifdef EQ_TRACE_EN
    chk("t2_mm_idx", 32'(mm_idx), 32'd1);
    chk("t2_mm_a", 32'(mm_a), 32'h23);
    chk("t2_mm_b", 32'(mm_b), 32'h22);
`endif
    a_complete = 1'b1; b_complete = 1'b1;
    step(); step(); step();
    chk("t2_done", 32'(done), 32'd1);
    chk("t2_mismatch_sticky", 32'(mismatch), 32'd1);

    // 3. model B not ready for 5 cycles: nothing delivered, then both at once
    a_complete = 1'b0; b_complete = 1'b0;
    do_start();
    chk("t3_mismatch_cleared", 32'(mismatch), 32'd0);
    in_tvalid = 1'b1; in_tdata = 8'h5a; b_in_tready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t3_stall_ready", 32'(in_tready), 32'd0);
      chk("t3_stall_valid", 32'({a_in_tvalid, b_in_tvalid}), 32'd0);
      step();
    end
    b_in_tready = 1'b1;
    #1;
    chk("t3_go_ready", 32'(in_tready), 32'd1);
    chk("t3_go_valid", 32'({a_in_tvalid, b_in_tvalid}), 32'd3);
    step();
    in_tvalid = 1'b0;
    chk("t3_cyc6", 32'(cyc_cnt), 32'd6);
    a_complete = 1'b1; b_complete = 1'b1;
    step(); step(); step();
    chk("t3_done", 32'(phase), 32'd4);

    // 4. length mismatch: A emits 4 beats, B emits 3
    a_complete = 1'b0; b_complete = 1'b0;
    do_start();
    for (int i = 0; i < 4; i++) begin
      a_out_tvalid = 1'b1; a_out_tdata = 8'(i + 1);
      b_out_tvalid = (i < 3); b_out_tdata = 8'(i + 1);
      step();
    end
    a_out_tvalid = 1'b0; b_out_tvalid = 1'b0;
    a_complete = 1'b1; b_complete = 1'b1;
    step();
    chk("t4_drain", 32'(phase), 32'd2);
    chk("t4_match3", 32'(match_cnt), 32'd3);
    step();
    chk("t4_check", 32'(phase), 32'd3);
    chk("t4_no_mismatch_yet", 32'(mismatch), 32'd0);
    step();
    chk("t4_done", 32'(phase), 32'd4);
    chk("t4_len_mismatch", 32'(mismatch), 32'd1);
    chk("t4_match_final", 32'(match_cnt), 32'd3);

    // 5. models never complete; buffer A fills; start in RUN ignored; cycle bound
    a_complete = 1'b0; b_complete = 1'b0;
    do_start();
    a_out_tvalid = 1'b1; a_out_tdata = 8'h40;
    repeat (4) step();
    a_out_tvalid = 1'b0;
    #1;
    chk("t5_a_full_ready", 32'(a_out_tready), 32'd0);
    chk("t5_a_full_step", 32'(a_step), 32'd0);
    chk("t5_b_step", 32'(b_step), 32'd1);
    chk("t5_b_ready", 32'(b_out_tready), 32'd1);
    do_start();
    chk("t5_start_ignored_phase", 32'(phase), 32'd1);
    chk("t5_start_ignored_cyc", 32'(cyc_cnt), 32'd5);
    chk("t5_start_ignored_buf", 32'(a_out_tready), 32'd0);
    repeat (10) step();
    chk("t5_still_run", 32'(phase), 32'd1);
    chk("t5_cyc15", 32'(cyc_cnt), 32'd15);
    step();
    chk("t5_bound_drain", 32'(phase), 32'd2);
    chk("t5_cyc_sat", 32'(cyc_cnt), 32'd15);
    step(); step();
    chk("t5_done", 32'(phase), 32'd4);
    chk("t5_cyc_final", 32'(cyc_cnt), 32'd15);
    chk("t5_len_mismatch", 32'(mismatch), 32'd1);

    // 6. async reset mid-run with data buffered, then a clean run
    do_start();
    a_out_tvalid = 1'b1; a_out_tdata = 8'h99;
    step(); step();
    a_out_tvalid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_phase", 32'(phase), 32'd0);
    chk("t6_rst_steps", 32'({a_step, b_step}), 32'd0);
    chk("t6_rst_cyc", 32'(cyc_cnt), 32'd0);
    chk("t6_rst_out_ready", 32'({a_out_tready, b_out_tready}), 32'd0);
    #2;
    rst_n = 1'b1;
    do_start();
    a_out_tvalid = 1'b1; b_out_tvalid = 1'b1;
    a_out_tdata = 8'h77; b_out_tdata = 8'h77;
    step();
    a_out_tvalid = 1'b0; b_out_tvalid = 1'b0;
    a_complete = 1'b1; b_complete = 1'b1;
    step(); step(); step();
    chk("t6_done", 32'(phase), 32'd4);
    chk("t6_match1", 32'(match_cnt), 32'd1);
    chk("t6_clean", 32'(mismatch), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
